// File: rtl/ibex_pkg.sv
// Shared FP types for the core's FP issue path and the FPU sequencer.
//   fp_alu_op_e      operator encoding understood by the bfloat16 FPU datapath
//   fpu_seq_state_e  state encoding of fpu_seq
package ibex_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [2:0] {
        FP_ALU_ADD  = 3'd0,
        FP_ALU_SUB  = 3'd1,
        FP_ALU_MUL  = 3'd2,
        FP_ALU_DIV  = 3'd3,
        FP_ALU_MIN  = 3'd4,
        FP_ALU_MAX  = 3'd5,
        FP_ALU_CVT  = 3'd6,
        FP_ALU_MADD = 3'd7
    } fp_alu_op_e;

    typedef enum logic [1:0] {
        FPU_SEQ_IDLE     = 2'd0,
        FPU_SEQ_EXEC     = 2'd1,
        FPU_SEQ_MADD_ADD = 2'd2,
        FPU_SEQ_DONE     = 2'd3
    } fpu_seq_state_e;

endpackage

// File: rtl/fpu_seq.sv
// fpu_seq: shares the combinational bfloat16 FPU with the FP issue path.
// Takes one request at a time, drives the FPU from captured operands,
// registers the FPU result and holds it on a valid/ready response channel.
// MADD is executed as MUL then ADD when FPU_SEQ_MADD_EN is defined; without
// the macro MADD completes immediately with result 0 and rsp_illegal_o set.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (abort in-flight op)
//   req_valid_i/req_ready_o, req_op_i, req_a_i, req_b_i, req_c_i, req_mode_i
//   fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o -> FPU
//   fpu_result_i <- FPU (combinational)
//   rsp_valid_o/rsp_ready_i, rsp_result_o, rsp_illegal_o, busy_o
//
// state    | meaning
// IDLE     | waiting for a request
// EXEC     | first FPU pass (MUL for MADD)
// MADD_ADD | second MADD pass: product + c
// DONE     | response valid, waiting for rsp_ready_i
import ibex_pkg::*;

module fpu_seq (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  fp_alu_op_e       req_op_i,
    input  logic [FP_W-1:0]  req_a_i,
    input  logic [FP_W-1:0]  req_b_i,
    input  logic [FP_W-1:0]  req_c_i,
    input  logic [1:0]       req_mode_i,
    output fp_alu_op_e       fpu_operator_o,
    output logic [FP_W-1:0]  fpu_operand_a_o,
    output logic [FP_W-1:0]  fpu_operand_b_o,
    output logic [1:0]       fpu_mode_o,
    input  logic [FP_W-1:0]  fpu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [FP_W-1:0]  rsp_result_o,
    output logic             rsp_illegal_o,
    output logic             busy_o
);

    fpu_seq_state_e  state_q, state_d;
    fp_alu_op_e      op_q;
    logic [FP_W-1:0] a_q, b_q, result_q;
    logic [1:0]      mode_q;
    logic            illegal_q;
    logic            accept;

`ifdef FPU_SEQ_MADD_EN
    logic [FP_W-1:0] c_q;
`else
    logic            unused_c;
    assign unused_c = ^req_c_i;
`endif

    assign accept        = req_ready_o && req_valid_i;
    assign busy_o        = (state_q != FPU_SEQ_IDLE);
    assign rsp_valid_o   = (state_q == FPU_SEQ_DONE);
    assign rsp_result_o  = result_q;
    assign rsp_illegal_o = illegal_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= FPU_SEQ_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        case (state_q)
            FPU_SEQ_IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) state_d = FPU_SEQ_EXEC;
            end
            FPU_SEQ_EXEC: begin
`ifdef FPU_SEQ_MADD_EN
                if (op_q == FP_ALU_MADD) state_d = FPU_SEQ_MADD_ADD;
                else                     state_d = FPU_SEQ_DONE;
`else
                state_d = FPU_SEQ_DONE;
`endif
            end
`ifdef FPU_SEQ_MADD_EN
            FPU_SEQ_MADD_ADD: state_d = FPU_SEQ_DONE;
`endif
            FPU_SEQ_DONE: begin
                if (rsp_ready_i) state_d = FPU_SEQ_IDLE;
            end
            default: state_d = FPU_SEQ_IDLE;
        endcase
        if (flush_i) state_d = FPU_SEQ_IDLE;
    end

    // Outside the active passes the FPU sees the captured request, so its
    // inputs stay quiet while idle or while a response is pending.
    always_comb begin
        fpu_operator_o  = op_q;
        fpu_operand_a_o = a_q;
        fpu_operand_b_o = b_q;
        fpu_mode_o      = mode_q;
`ifdef FPU_SEQ_MADD_EN
        if (state_q == FPU_SEQ_EXEC && op_q == FP_ALU_MADD) begin
            fpu_operator_o = FP_ALU_MUL;
        end else if (state_q == FPU_SEQ_MADD_ADD) begin
            // Product is re-fed truncated to its bfloat16 half.
            fpu_operator_o  = FP_ALU_ADD;
            fpu_operand_a_o = {result_q[FP_W-1:16], 16'd0};
            fpu_operand_b_o = c_q;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= FP_ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef FPU_SEQ_MADD_EN
            c_q       <= '0;
`endif
        end else begin
            if (accept) begin
                op_q   <= req_op_i;
                a_q    <= req_a_i;
                b_q    <= req_b_i;
                mode_q <= req_mode_i;
`ifdef FPU_SEQ_MADD_EN
                c_q    <= req_c_i;
`endif
            end
            if (!flush_i) begin
                if (state_q == FPU_SEQ_EXEC) begin
`ifdef FPU_SEQ_MADD_EN
                    result_q  <= fpu_result_i;
                    illegal_q <= 1'b0;
`else
                    if (op_q == FP_ALU_MADD) begin
                        result_q  <= '0;
                        illegal_q <= 1'b1;
                    end else begin
                        result_q  <= fpu_result_i;
                        illegal_q <= 1'b0;
                    end
`endif
                end
`ifdef FPU_SEQ_MADD_EN
                if (state_q == FPU_SEQ_MADD_ADD) result_q <= fpu_result_i;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq with a small table-driven FPU stand-in.
import ibex_pkg::*;

module tb_fpu_seq;

    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;
    localparam logic [31:0] SIX   = 32'h40C0_0000;
    localparam logic [31:0] SEVEN = 32'h40E0_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, req_valid_i, rsp_ready_i;
    logic        req_ready_o, rsp_valid_o, rsp_illegal_o, busy_o;
    fp_alu_op_e  req_op_i, fpu_operator_o;
    logic [31:0] req_a_i, req_b_i, req_c_i;
    logic [1:0]  req_mode_i, fpu_mode_o;
    logic [31:0] fpu_operand_a_o, fpu_operand_b_o, fpu_result_i, rsp_result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fpu_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_c_i(req_c_i), .req_mode_i(req_mode_i),
        .fpu_operator_o(fpu_operator_o), .fpu_operand_a_o(fpu_operand_a_o),
        .fpu_operand_b_o(fpu_operand_b_o), .fpu_mode_o(fpu_mode_o),
        .fpu_result_i(fpu_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_illegal_o(rsp_illegal_o),
        .busy_o(busy_o)
    );

    // FPU stand-in: exact answers for the directed vectors, a tagged
    // pattern otherwise so unexpected operands show up in the result.
    always_comb begin
        fpu_result_i = {fpu_operand_a_o[31:16] ^ fpu_operand_b_o[31:16], 13'd0, fpu_operator_o};
        case (fpu_operator_o)
            FP_ALU_ADD: begin
                if (fpu_operand_a_o == ONE && fpu_operand_b_o == TWO) fpu_result_i = THREE;
                else if (fpu_operand_a_o == SIX && fpu_operand_b_o == ONE) fpu_result_i = SEVEN;
            end
            FP_ALU_SUB: if (fpu_operand_a_o == THREE && fpu_operand_b_o == ONE) fpu_result_i = TWO;
            FP_ALU_MUL: if (fpu_operand_a_o == TWO && fpu_operand_b_o == THREE) fpu_result_i = SIX;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready_o), 32'd1);
        check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, " rsp_result"}, rsp_result_o, 32'd0);
        check({tag, " rsp_illegal"}, 32'(rsp_illegal_o), 32'd0);
        check({tag, " busy"}, 32'(busy_o), 32'd0);
        check({tag, " fpu_operator"}, 32'(fpu_operator_o), 32'(FP_ALU_ADD));
        check({tag, " fpu_a"}, fpu_operand_a_o, 32'd0);
        check({tag, " fpu_b"}, fpu_operand_b_o, 32'd0);
        check({tag, " fpu_mode"}, 32'(fpu_mode_o), 32'd0);
    endtask

    task automatic drive_req(input fp_alu_op_e op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_c_i     = c;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        req_op_i = FP_ALU_ADD; req_a_i = '0; req_b_i = '0; req_c_i = '0; req_mode_i = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        step();

        // ADD 1.0 + 2.0 with 5 cycles of backpressure
        drive_req(FP_ALU_ADD, ONE, TWO, 32'd0);
        req_mode_i = 2'd2;
        check("add req_ready", 32'(req_ready_o), 32'd1);
        step();                                   // T+1
        req_valid_i = 1'b0;
        check("add exec busy", 32'(busy_o), 32'd1);
        check("add exec valid", 32'(rsp_valid_o), 32'd0);
        check("add exec operator", 32'(fpu_operator_o), 32'(FP_ALU_ADD));
        check("add exec a", fpu_operand_a_o, ONE);
        check("add exec b", fpu_operand_b_o, TWO);
        check("add exec mode", 32'(fpu_mode_o), 32'd2);
        step();                                   // T+2
        req_mode_i = 2'd0;
        check("add valid T+2", 32'(rsp_valid_o), 32'd1);
        check("add result", rsp_result_o, THREE);
        check("add illegal", 32'(rsp_illegal_o), 32'd0);
        drive_req(FP_ALU_SUB, THREE, ONE, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold valid", 32'(rsp_valid_o), 32'd1);
            check("hold result", rsp_result_o, THREE);
            check("hold req_ready", 32'(req_ready_o), 32'd0);
            check("hold fpu operator", 32'(fpu_operator_o), 32'(FP_ALU_ADD));
        end
        rsp_ready_i = 1'b1;
        step();                                   // handshake done, IDLE
        rsp_ready_i = 1'b0;
        check("after hs valid", 32'(rsp_valid_o), 32'd0);
        check("after hs busy", 32'(busy_o), 32'd0);
        check("after hs req_ready", 32'(req_ready_o), 32'd1);
        step();                                   // SUB accepted -> EXEC
        req_valid_i = 1'b0;
        check("sub exec busy", 32'(busy_o), 32'd1);
        check("sub exec operator", 32'(fpu_operator_o), 32'(FP_ALU_SUB));
        check("sub exec b not negated", fpu_operand_b_o, ONE);
        step();
        check("sub valid", 32'(rsp_valid_o), 32'd1);
        check("sub result", rsp_result_o, TWO);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // MADD 2.0 * 3.0 + 1.0
        drive_req(FP_ALU_MADD, TWO, THREE, ONE);
        step();                                   // T+1
        req_valid_i = 1'b0;
`ifdef FPU_SEQ_MADD_EN
        check("madd pass1 operator", 32'(fpu_operator_o), 32'(FP_ALU_MUL));
        check("madd pass1 a", fpu_operand_a_o, TWO);
        check("madd pass1 b", fpu_operand_b_o, THREE);
        step();                                   // T+2
        check("madd pass2 valid", 32'(rsp_valid_o), 32'd0);
        check("madd pass2 operator", 32'(fpu_operator_o), 32'(FP_ALU_ADD));
        check("madd pass2 a", fpu_operand_a_o, SIX);
        check("madd pass2 b", fpu_operand_b_o, ONE);
        step();                                   // T+3
        check("madd valid T+3", 32'(rsp_valid_o), 32'd1);
        check("madd result", rsp_result_o, SEVEN);
        check("madd illegal", 32'(rsp_illegal_o), 32'd0);
`else
        check("madd exec busy", 32'(busy_o), 32'd1);
        step();                                   // T+2
        check("madd valid T+2", 32'(rsp_valid_o), 32'd1);
        check("madd result zero", rsp_result_o, 32'd0);
        check("madd illegal", 32'(rsp_illegal_o), 32'd1);
`endif
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("madd hs idle", 32'(busy_o), 32'd0);

        // Flush mid-operation with a competing request
        drive_req(FP_ALU_MADD, TWO, THREE, ONE);
        step();                                   // EXEC
`ifdef FPU_SEQ_MADD_EN
        req_valid_i = 1'b0;
        step();                                   // MADD_ADD
        check("flush in madd_add", 32'(fpu_operator_o), 32'(FP_ALU_ADD));
`endif
        drive_req(FP_ALU_ADD, ONE, TWO, 32'd0);
        flush_i = 1'b1;
        #1;
        check("flush req_ready", 32'(req_ready_o), 32'd0);
        step();
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        check("flush idle busy", 32'(busy_o), 32'd0);
        check("flush no valid", 32'(rsp_valid_o), 32'd0);
        step();
        check("flush req not taken", 32'(busy_o), 32'd0);
        check("flush still no valid", 32'(rsp_valid_o), 32'd0);

        // Asynchronous reset while in EXEC
        drive_req(FP_ALU_ADD, ONE, TWO, 32'd0);
        step();                                   // EXEC
        req_valid_i = 1'b0;
        check("pre-reset busy", 32'(busy_o), 32'd1);
        #3;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        check("post-reset no rsp", 32'(rsp_valid_o), 32'd0);
        step();
        check("post-reset still idle", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
